// File: rtl/s2_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : s2_share_arbiter_pkg
//  Purpose  : Shared definitions for the S2 shared-register arbiter:
//             FSM state encoding, requester count and round-robin
//             pointer width.
//  Revision : 1.0  initial release
// ============================================================================
package s2_share_arbiter_pkg;

   localparam int c_NREQ  = 4;
   localparam int c_PTR_W = 2;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/s2_share_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick4
//  Purpose  : Combinational round-robin picker for 4 requesters. Scans
//             ptr, ptr+1, ptr+2, ptr+3 (mod 4) and returns the first
//             requester found.
//  Ports    : req    in  4  request levels
//             ptr    in  2  highest-priority index this round
//             any    out 1  at least one request present
//             idx    out 2  selected requester index
//             onehot out 4  one-hot of idx (all zero when any=0)
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick4
   import s2_share_arbiter_pkg::*;
(
   input  logic [c_NREQ-1:0]  req,
   input  logic [c_PTR_W-1:0] ptr,
   output logic               any,
   output logic [c_PTR_W-1:0] idx,
   output logic [c_NREQ-1:0]  onehot
);

   logic               w_found;
   logic [c_PTR_W-1:0] w_cand;

   // The 2-bit addition wraps naturally, giving the mod-4 scan order.
   always_comb begin
      w_found = 1'b0;
      w_cand  = '0;
      idx     = '0;
      for (int i = 0; i < c_NREQ; i++) begin
         w_cand = ptr + c_PTR_W'(i);
         if (!w_found && req[w_cand]) begin
            idx     = w_cand;
            w_found = 1'b1;
         end
      end
   end

   assign any    = |req;
   assign onehot = any ? (c_NREQ'(1) << idx) : '0;

endmodule
`default_nettype wire

// File: rtl/s2_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : s2_share_arbiter
//  Purpose  : Round-robin arbiter sharing one N-bit storage register among
//             4 requesters. The owner's data lane is steered through a 4:1
//             select into the register on its write strobe; the owner
//             releases via last or by dropping its request.
//  Config   : S2ARB_TIMEOUT_EN - when defined, an 8-bit hold counter forces
//             release after MAX_HOLD consecutive OWN cycles and pulses
//             timeout. When undefined, timeout is tied low.
//  Ports    : CLK     in  1    clock, rising edge
//             CLR     in  1    asynchronous active-high reset
//             req     in  4    request levels
//             wr      in  4    write strobes (owner only)
//             last    in  4    release strobes (owner only)
//             din     in  4*N  data lanes, lane k = din[k*N +: N]
//             gnt     out 4    registered one-hot grant
//             sel     out 2    current / most recent owner
//             busy    out 1    high while in OWN
//             timeout out 1    one-cycle pulse on forced release
//             out     out N    shared register contents
//  Revision : 1.0  initial release
// ============================================================================
module s2_share_arbiter
   import s2_share_arbiter_pkg::*;
#(
   parameter int N        = 8,
   parameter int MAX_HOLD = 15
)
(
   input  logic                CLK,
   input  logic                CLR,
   input  logic [c_NREQ-1:0]   req,
   input  logic [c_NREQ-1:0]   wr,
   input  logic [c_NREQ-1:0]   last,
   input  logic [c_NREQ*N-1:0] din,
   output logic [c_NREQ-1:0]   gnt,
   output logic [c_PTR_W-1:0]  sel,
   output logic                busy,
   output logic                timeout,
   output logic [N-1:0]        out
);

   // Out-of-range MAX_HOLD leaves this marker block in the hierarchy.
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
   end

   state_t              r_state,   w_state_nxt;
   logic [c_PTR_W-1:0]  r_ptr,     w_ptr_nxt;
   logic [c_NREQ-1:0]   r_gnt,     w_gnt_nxt;
   logic [c_PTR_W-1:0]  r_sel,     w_sel_nxt;
   logic                r_timeout, w_timeout_nxt;
   logic [N-1:0]        r_out,     w_out_nxt;

   logic                w_any;
   logic [c_PTR_W-1:0]  w_idx;
   logic [c_NREQ-1:0]   w_onehot;
   logic                w_owner_rel;
   logic                w_force;
   logic [N-1:0]        w_lane [c_NREQ];

   rr_pick4 u_pick (
      .req    (req),
      .ptr    (r_ptr),
      .any    (w_any),
      .idx    (w_idx),
      .onehot (w_onehot)
   );

   for (genvar k = 0; k < c_NREQ; k++) begin : g_lane
      assign w_lane[k] = din[k*N +: N];
   end

   // Owner-initiated release: explicit last or request withdrawn.
   assign w_owner_rel = last[r_sel] | ~req[r_sel];

`ifdef S2ARB_TIMEOUT_EN
   localparam logic [7:0] c_HOLD_LIM = 8'(MAX_HOLD);

   logic [7:0] r_hold;
   logic [7:0] w_hold_inc;

   assign w_hold_inc = r_hold + 8'd1;
   // Forced release only when the owner is not already letting go.
   assign w_force    = (r_state == S_OWN) & ~w_owner_rel & (w_hold_inc == c_HOLD_LIM);

   // Held at zero in IDLE, so it starts from zero on every new grant.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR)
         r_hold <= '0;
      else if (r_state == S_IDLE)
         r_hold <= '0;
      else
         r_hold <= w_hold_inc;
   end
`else
   assign w_force = 1'b0;
`endif

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_gnt     <= '0;
         r_sel     <= '0;
         r_timeout <= 1'b0;
         r_out     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_gnt     <= w_gnt_nxt;
         r_sel     <= w_sel_nxt;
         r_timeout <= w_timeout_nxt;
         r_out     <= w_out_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_gnt_nxt     = r_gnt;
      w_sel_nxt     = r_sel;
      w_timeout_nxt = 1'b0;
      w_out_nxt     = r_out;
      case (r_state)
         S_IDLE: begin
            w_gnt_nxt = '0;
            if (w_any) begin
               w_state_nxt = S_OWN;
               w_gnt_nxt   = w_onehot;
               w_sel_nxt   = w_idx;
            end
         end
         S_OWN: begin
            // A write on the releasing edge still lands.
            if (wr[r_sel])
               w_out_nxt = w_lane[r_sel];
            if (w_owner_rel || w_force) begin
               w_state_nxt   = S_IDLE;
               w_gnt_nxt     = '0;
               w_ptr_nxt     = r_sel + c_PTR_W'(1);
               w_timeout_nxt = w_force;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   assign gnt     = r_gnt;
   assign sel     = r_sel;
   assign busy    = (r_state == S_OWN);
   assign timeout = r_timeout;
   assign out     = r_out;

endmodule
`default_nettype wire

// File: tb/tb_s2_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_s2_share_arbiter
//  Purpose  : Self-checking bench for s2_share_arbiter: directed vector
//             table, hand-written multi-cycle sequences (async reset,
//             fairness, hold/timeout) and randomized stimulus against a
//             behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_s2_share_arbiter;

   localparam int N = 8;
`ifdef S2ARB_TIMEOUT_EN
   localparam int MH    = 4;
   localparam bit TO_EN = 1'b1;
`else
   localparam int MH    = 15;
   localparam bit TO_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        CLR;
   logic [3:0]  req, wr, last;
   logic [31:0] din;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic        busy, timeout;
   logic [7:0]  out;

   s2_share_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
      .CLK     (CLK),
      .CLR     (CLR),
      .req     (req),
      .wr      (wr),
      .last    (last),
      .din     (din),
      .gnt     (gnt),
      .sel     (sel),
      .busy    (busy),
      .timeout (timeout),
      .out     (out)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs, then advance one rising edge and settle.
   task automatic apply(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l,
                        input logic [31:0] d);
      req = r; wr = w; last = l; din = d;
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_reset();
      CLR = 1'b1;
      req = '0; wr = '0; last = '0; din = '0;
      @(posedge CLK);
      #1;
      CLR = 1'b0;
   endtask

   // ---------------- behavioural reference model ----------------
   int         m_owner;   // -1 when nobody holds the register
   int         m_ptr;
   int         m_hold;
   logic [7:0] m_out;
   logic [1:0] m_sel;
   bit         m_to;

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_hold = 0; m_out = '0; m_sel = '0; m_to = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] rq, input logic [3:0] w, input logic [3:0] l,
                             input logic [31:0] d);
      bit rel, frc;
      int k;
      m_to = 1'b0;
      if (m_owner < 0) begin
         for (int i = 0; i < 4; i++) begin
            k = (m_ptr + i) % 4;
            if (rq[k]) begin
               m_owner = k; m_sel = 2'(k); m_hold = 0;
               break;
            end
         end
      end else begin
         k = m_owner;
         if (w[k]) m_out = d[k*8 +: 8];
         rel = l[k] || !rq[k];
         m_hold++;
         frc = TO_EN && !rel && (m_hold == MH);
         if (rel || frc) begin
            m_owner = -1;
            m_ptr   = (k + 1) % 4;
            m_to    = frc;
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [3:0]  req, wr, last;
      logic [31:0] din;
      logic [3:0]  gnt;
      logic [1:0]  sel;
      logic        busy;
      logic [7:0]  out;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [3:0] eg;
      //           req      wr       last     din            gnt      sel   busy  out
      tbl[0]  = '{4'b0100, 4'b0000, 4'b0000, 32'h00000000, 4'b0100, 2'd2, 1'b1, 8'h00};
      tbl[1]  = '{4'b0100, 4'b0100, 4'b0000, 32'h003C0000, 4'b0100, 2'd2, 1'b1, 8'h3C};
      tbl[2]  = '{4'b0100, 4'b0000, 4'b0100, 32'h00000000, 4'b0000, 2'd2, 1'b0, 8'h3C};
      tbl[3]  = '{4'b0011, 4'b0000, 4'b0000, 32'h00000000, 4'b0001, 2'd0, 1'b1, 8'h3C};
      tbl[4]  = '{4'b0011, 4'b0000, 4'b0001, 32'h00000000, 4'b0000, 2'd0, 1'b0, 8'h3C};
      tbl[5]  = '{4'b0010, 4'b1000, 4'b0000, 32'hFF000000, 4'b0010, 2'd1, 1'b1, 8'h3C};
      tbl[6]  = '{4'b1010, 4'b1000, 4'b1000, 32'hFF000000, 4'b0010, 2'd1, 1'b1, 8'h3C};
      tbl[7]  = '{4'b0010, 4'b0010, 4'b0010, 32'h00005A00, 4'b0000, 2'd1, 1'b0, 8'h5A};
      tbl[8]  = '{4'b0000, 4'b1111, 4'b1111, 32'h77777777, 4'b0000, 2'd1, 1'b0, 8'h5A};
      tbl[9]  = '{4'b0001, 4'b0000, 4'b0000, 32'h00000000, 4'b0001, 2'd0, 1'b1, 8'h5A};
      tbl[10] = '{4'b0000, 4'b0001, 4'b0000, 32'h00000011, 4'b0000, 2'd0, 1'b0, 8'h11};

      // Reset state
      CLR = 1'b1; req = '0; wr = '0; last = '0; din = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_gnt",     32'(gnt),     32'h0);
      chk("reset_sel",     32'(sel),     32'h0);
      chk("reset_busy",    32'(busy),    32'h0);
      chk("reset_timeout", 32'(timeout), 32'h0);
      chk("reset_out",     32'(out),     32'h0);
      CLR = 1'b0;

      // Single owner, wrap, ignored strobes, write+release, drop-request write
      for (int i = 0; i < 11; i++) begin
         apply(tbl[i].req, tbl[i].wr, tbl[i].last, tbl[i].din);
         chk($sformatf("tbl%0d_gnt", i),     32'(gnt),     32'(tbl[i].gnt));
         chk($sformatf("tbl%0d_sel", i),     32'(sel),     32'(tbl[i].sel));
         chk($sformatf("tbl%0d_busy", i),    32'(busy),    32'(tbl[i].busy));
         chk($sformatf("tbl%0d_out", i),     32'(out),     32'(tbl[i].out));
         chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'h0);
      end

      // Asynchronous reset in the middle of an ownership with out=A5
      apply(4'b0001, 4'b0000, 4'b0000, 32'h0);
      chk("ar_pre_gnt", 32'(gnt), 32'h1);
      apply(4'b0001, 4'b0001, 4'b0000, 32'h000000A5);
      chk("ar_pre_out", 32'(out), 32'hA5);
      #2 CLR = 1'b1;
      #1;
      chk("ar_gnt",  32'(gnt),  32'h0);
      chk("ar_busy", 32'(busy), 32'h0);
      chk("ar_out",  32'(out),  32'h0);
      chk("ar_sel",  32'(sel),  32'h0);
      #1 CLR = 1'b0;
      // Pointer restarts at 0: from {1,3} requester 1 wins
      apply(4'b1010, 4'b0000, 4'b0000, 32'h0);
      chk("ar_post_gnt", 32'(gnt), 32'h2);
      apply(4'b1010, 4'b0000, 4'b0010, 32'h0);
      chk("ar_post_bubble", 32'(gnt), 32'h0);
      apply(4'b1010, 4'b0000, 4'b0000, 32'h0);
      chk("ar_post_next", 32'(gnt), 32'h8);
      apply(4'b0000, 4'b0000, 4'b0000, 32'h0);

      // Fairness: all four requesting, each owner writes once then releases
      pulse_reset();
      for (int g = 0; g < 8; g++) begin
         logic [7:0] v;
         v  = 8'h10 + 8'(g);
         eg = 4'b0001 << (g % 4);
         apply(4'b1111, 4'b0000, 4'b0000, 32'h0);
         chk($sformatf("fair%0d_gnt", g), 32'(gnt), 32'(eg));
         chk($sformatf("fair%0d_sel", g), 32'(sel), 32'(g % 4));
         apply(4'b1111, eg, eg, {4{v}});
         chk($sformatf("fair%0d_bubble", g), 32'(gnt), 32'h0);
         chk($sformatf("fair%0d_out", g),    32'(out), 32'(v));
      end

      // Long hold by owner 0 with requester 1 waiting
      pulse_reset();
      apply(4'b0011, 4'b0000, 4'b0000, 32'h0);
      chk("hold_enter", 32'(gnt), 32'h1);
`ifdef S2ARB_TIMEOUT_EN
      for (int c = 1; c < MH; c++) begin
         apply(4'b0011, 4'b0000, 4'b0000, 32'h0);
         chk($sformatf("to_hold%0d_gnt", c), 32'(gnt),     32'h1);
         chk($sformatf("to_hold%0d_to", c),  32'(timeout), 32'h0);
      end
      apply(4'b0011, 4'b0001, 4'b0000, 32'h00000042);
      chk("to_rel_gnt",  32'(gnt),     32'h0);
      chk("to_rel_busy", 32'(busy),    32'h0);
      chk("to_rel_to",   32'(timeout), 32'h1);
      chk("to_rel_out",  32'(out),     32'h42);
      apply(4'b0011, 4'b0000, 4'b0000, 32'h0);
      chk("to_next_gnt", 32'(gnt),     32'h2);
      chk("to_next_to",  32'(timeout), 32'h0);
`else
      for (int c = 1; c < 20; c++) begin
         apply(4'b0011, 4'b0000, 4'b0000, 32'h0);
         chk($sformatf("hold%0d_gnt", c), 32'(gnt),     32'h1);
         chk($sformatf("hold%0d_to", c),  32'(timeout), 32'h0);
      end
`endif

      // Randomized run against the reference model
      pulse_reset();
      model_reset();
      for (int c = 0; c < 400; c++) begin
         logic [3:0]  rr, rw, rl;
         logic [31:0] rd;
         rr = 4'($urandom | $urandom);
         rw = 4'($urandom);
         rl = 4'($urandom & $urandom & $urandom);
         rd = $urandom;
         apply(rr, rw, rl, rd);
         model_step(rr, rw, rl, rd);
         eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
         chk($sformatf("rnd%0d_gnt", c),     32'(gnt),     32'(eg));
         chk($sformatf("rnd%0d_sel", c),     32'(sel),     32'(m_sel));
         chk($sformatf("rnd%0d_busy", c),    32'(busy),    32'(m_owner >= 0));
         chk($sformatf("rnd%0d_timeout", c), 32'(timeout), 32'(m_to));
         chk($sformatf("rnd%0d_out", c),     32'(out),     32'(m_out));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
